// File: rtl/simd_divider.sv
// SIMD unsigned restoring divider: DW-bit operands split into 8/16/32/64-bit lanes,
// one shift-subtract iteration per clock in every lane, valid/ready on both sides.
module simd_divider #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [0:DW-1] op1,
  input  logic [0:DW-1] op2,
  input  logic [1:0]    ww,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [0:DW-1] quot,
  output logic [0:DW-1] rem,
  output logic          dz
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [1:0]     wsel;
  logic [5:0]     cnt;
  logic [DW-1:0]  q_r;
  logic [DW-1:0]  r_r;
  logic [DW-1:0]  d_r;
  logic           dz_r;

  logic [DW-1:0]  a_in;
  logic [DW-1:0]  b_in;
  logic [DW-1:0]  q_nx [4];
  logic [DW-1:0]  r_nx [4];
  logic [3:0]     zero_w;

  assign a_in = op1;
  assign b_in = op2;

  // One iteration datapath per lane width; the dividend register doubles as the
  // quotient register, quotient bits entering at each lane's LSB as it shifts left.
  for (genvar w = 0; w < 4; w++) begin : g_width
    localparam int W = 8 << w;
    localparam int N = DW / W;
    logic [N-1:0] zl;

    for (genvar p = 0; p < N; p++) begin : g_lane
      localparam int B = p * W;
      logic [W:0] sh;
      logic [W:0] df;
      logic       ge;

      always_comb begin
        sh = {r_r[B+:W], q_r[B+W-1]};
        df = sh - {1'b0, d_r[B+:W]};
        ge = (sh >= {1'b0, d_r[B+:W]});
      end

      assign r_nx[w][B+:W] = ge ? df[W-1:0] : sh[W-1:0];
      assign q_nx[w][B+:W] = {q_r[B+:W-1], ge};
      assign zl[p]         = (b_in[B+:W] == '0);
    end

    assign zero_w[w] = |zl;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quot      <= '0;
      rem       <= '0;
      dz        <= 1'b0;
      dz_r      <= 1'b0;
      cnt       <= '0;
      wsel      <= '0;
      q_r       <= '0;
      r_r       <= '0;
      d_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            q_r      <= a_in;
            d_r      <= b_in;
            r_r      <= '0;
            wsel     <= ww;
            cnt      <= 6'((8 << ww) - 1);
            dz_r     <= zero_w[ww];
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          q_r <= q_nx[wsel];
          r_r <= r_nx[wsel];
          cnt <= cnt - 6'd1;
          if (cnt == 6'd0) begin
            quot      <= q_nx[wsel];
            rem       <= r_nx[wsel];
            dz        <= dz_r;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simd_divider.sv
// Self-checking bench for simd_divider: lane-level arithmetic model, directed cases,
// backpressure, mid-run reset and a randomised regression over all lane widths.
module tb_simd_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] op1;
  logic [63:0] op2;
  logic [1:0]  ww;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] quot;
  logic [63:0] rem;
  logic        dz;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q;
  logic [63:0] exp_r;
  logic        exp_dz;
  logic        chk_en = 1'b0;

  always #5 clk = ~clk;

  simd_divider #(.DW(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .ww(ww), .out_valid(out_valid), .out_ready(out_ready),
    .quot(quot), .rem(rem), .dz(dz)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Per-lane reference: plain / and %, with the divide-by-zero result the algorithm yields.
  function automatic void model(input logic [1:0] w, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] q, output logic [63:0] r, output logic z);
    int ew = 8 << w;
    int lanes = 64 / ew;
    logic [63:0] m, av, bv, qv, rv;
    m = (ew == 64) ? '1 : ((64'd1 << ew) - 64'd1);
    q = '0;
    r = '0;
    z = 1'b0;
    for (int k = 0; k < lanes; k++) begin
      int sh = 64 - (k + 1) * ew;
      av = (a >> sh) & m;
      bv = (b >> sh) & m;
      if (bv == 64'd0) begin
        qv = m;
        rv = av;
        z  = 1'b1;
      end else begin
        qv = av / bv;
        rv = av % bv;
      end
      q |= qv << sh;
      r |= rv << sh;
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en && !reset && out_valid) begin
      check("quot", quot, exp_q);
      check("rem", rem, exp_r);
      check("dz", {63'd0, dz}, {63'd0, exp_dz});
      check("in_ready_in_done", {63'd0, in_ready}, 64'd0);
    end
  end

  task automatic run_op(input logic [1:0] w, input logic [63:0] a, input logic [63:0] b,
                        input int hold);
    int ew = 8 << w;
    int n;
    bit got;
    model(w, a, b, exp_q, exp_r, exp_dz);
    @(negedge clk);
    in_valid = 1'b1;
    op1 = a;
    op2 = b;
    ww  = w;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept_timeout", {63'd0, got}, 64'd1);
    if (!got) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op1 = {$urandom, $urandom};
    op2 = {$urandom, $urandom};
    ww  = 2'($urandom);
    n   = 0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("done_timeout", {63'd0, got}, 64'd1);
    check("latency_edges", 64'(n), 64'(ew));
    repeat (hold) @(negedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release_out_valid", {63'd0, out_valid}, 64'd0);
    check("release_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pq, pr, a, b;
    logic        pz;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op1 = '0;
    op2 = '0;
    ww = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_quot", quot, 64'd0);
    check("rst_rem", rem, 64'd0);
    check("rst_dz", {63'd0, dz}, 64'd0);
    chk_en = 1'b1;

    a = 64'h64FF0700_00000000;
    b = 64'h07100705_01010101;
    model(2'd0, a, b, pq, pr, pz);
    check("pin8_q", pq, 64'h0E0F0100_00000000);
    check("pin8_r", pr, 64'h020F0000_00000000);
    check("pin8_dz", {63'd0, pz}, 64'd0);
    run_op(2'd0, a, b, 0);

    model(2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, pq, pr, pz);
    check("pin64_q", pq, 64'h5555_5555_5555_5555);
    check("pin64_r", pr, 64'd0);
    run_op(2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 0);

    a = 64'h0010_0020_1234_0003;
    b = 64'h0003_0007_0000_0002;
    model(2'd1, a, b, pq, pr, pz);
    check("pin16_q", pq, 64'h0005_0004_FFFF_0001);
    check("pin16_r", pr, 64'h0001_0004_1234_0001);
    check("pin16_dz", {63'd0, pz}, 64'd1);
    run_op(2'd1, a, b, 20);

    run_op(2'd2, 64'd0, 64'h0000_0005_0000_0009, 1);

    @(negedge clk);
    in_valid = 1'b1;
    op1 = {$urandom, $urandom};
    op2 = {$urandom, $urandom};
    ww  = 2'd2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_quot", quot, 64'd0);
    check("midrst_rem", rem, 64'd0);
    check("midrst_dz", {63'd0, dz}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);

    a = 64'd100;
    b = 64'h0000_0001_0000_0007;
    model(2'd2, a, b, pq, pr, pz);
    check("pin100_q", pq, 64'd14);
    check("pin100_r", pr, 64'd2);
    run_op(2'd2, a, b, 0);

    for (int i = 0; i < 1200; i++) begin
      logic [1:0] w;
      w = 2'($urandom_range(0, 3));
      a = {$urandom, $urandom} >> $urandom_range(0, 8);
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 15) == 0) b = '0;
      run_op(w, a, b, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
